parallel_serial_tx: RTL

- Transmit-side partner of the serial-to-parallel receiver. Converts a byte stream, with a valid/ready handshake, into a 1-bit serial stream, MSB first, one bit per CLK.
- Fills every idle symbol slot with the COM symbol (0xBC) so the downstream receiver can find byte alignment.
- After reset it sends a fixed preamble of COM symbols before any payload byte.

---
 rtl/parallel_serial_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/parallel_serial_tx.sv
// Byte stream to MSB-first serial line with COM idle fill and preamble.
// Optional BYTE_CNT output enabled by PARALLEL_SERIAL_TX_BYTE_CNT_EN.
module parallel_serial_tx #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned MIN_COM    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DATA_IN,
  input  logic        VALID_IN,
  output logic        READY,
  output logic        DATA_OUT,
`ifdef PARALLEL_SERIAL_TX_BYTE_CNT_EN
  output logic        LINK_UP,
  output logic [15:0] BYTE_CNT
`else
  output logic        LINK_UP
`endif
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t     state, state_nx;
  logic [7:0] sr, sr_nx;
  logic [2:0] bc, bc_nx;
  logic [7:0] hold, hold_nx;
  logic       hfull, hfull_nx;
  logic [7:0] pc, pc_nx;
  logic       link, link_nx;
  logic       ready;
  logic       load_hold;

  assign DATA_OUT = sr[7];
  assign READY    = ready;
  assign LINK_UP  = link;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= INIT;
      sr    <= COM_SYMBOL;
      bc    <= 3'd0;
      hold  <= 8'd0;
      hfull <= 1'b0;
      pc    <= 8'd0;
      link  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      bc    <= bc_nx;
      hold  <= hold_nx;
      hfull <= hfull_nx;
      pc    <= pc_nx;
      link  <= link_nx;
      ready <= ~hfull_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sr_nx     = {sr[6:0], 1'b0};
    bc_nx     = bc + 3'd1;
    hold_nx   = hold;
    hfull_nx  = hfull;
    pc_nx     = pc;
    link_nx   = link;
    load_hold = 1'b0;
    if (VALID_IN && ready) begin
      hold_nx  = DATA_IN;
      hfull_nx = 1'b1;
    end
    if (bc == 3'd7) begin
      sr_nx = COM_SYMBOL;
      unique case (state)
        INIT: begin
          pc_nx = pc + 8'd1;
          // the preamble is exactly MIN_COM symbols: payload may follow it
          if (pc == 8'(MIN_COM - 1)) begin
            state_nx  = RUN;
            link_nx   = 1'b1;
            load_hold = hfull;
          end
        end
        RUN:     load_hold = hfull;
        default: state_nx  = INIT;
      endcase
      if (load_hold) begin
        sr_nx    = hold;
        hfull_nx = 1'b0;
      end
    end
  end

`ifdef PARALLEL_SERIAL_TX_BYTE_CNT_EN
  logic [15:0] byte_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          byte_cnt <= 16'd0;
    else if (load_hold) byte_cnt <= byte_cnt + 16'd1;
  end

  assign BYTE_CNT = byte_cnt;
`endif

endmodule
